// File: rtl/mem_reg_fifo_if.sv
// Four-phase return-to-zero link carrying a 1-of-N encoded word plus its acknowledge.
interface link_intf #(
    parameter int W = 4
);
    logic [W-1:0] data;
    logic         ack;

    modport in  (input data, output ack);
    modport out (output data, input ack);
endinterface

// File: rtl/mem_reg_fifo.sv
// Clocked FIFO between two four-phase 1-of-RAIL_NUM links, with occupancy and sticky codeword error.
// Define MEM_REG_FIFO_SYNC_EN to pass in.data and out.ack through 2-flop synchronisers.
module mem_reg_fifo #(
    parameter int REG_WIDTH = 2,
    parameter int RAIL_NUM  = 2,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    link_intf.in                         in,
    link_intf.out                        out,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         err
);
    localparam int W  = REG_WIDTH * RAIL_NUM;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {CW_SPACER, CW_COMPLETE, CW_INVALID, CW_PARTIAL} cw_t;
    typedef enum logic {IN_IDLE, IN_ACK} in_st_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_DATA, OUT_RTZ} out_st_t;

    function automatic cw_t classify(input logic [W-1:0] w);
        logic any_multi;
        logic all_one;
        any_multi = 1'b0;
        all_one   = 1'b1;
        for (int d = 0; d < REG_WIDTH; d++) begin
            if ($countones(w[d*RAIL_NUM +: RAIL_NUM]) > 1)  any_multi = 1'b1;
            if ($countones(w[d*RAIL_NUM +: RAIL_NUM]) != 1) all_one   = 1'b0;
        end
        if (w == '0)     return CW_SPACER;
        if (any_multi)   return CW_INVALID;
        if (all_one)     return CW_COMPLETE;
        return CW_PARTIAL;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [W-1:0]  in_word;
    logic          out_ack_s;

`ifdef MEM_REG_FIFO_SYNC_EN
    logic [W-1:0]  in_data_p0, in_data_p1;
    logic          out_ack_p0, out_ack_p1;

    // Synchroniser stages for links driven from unclocked logic
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_data_p0 <= '0;
            in_data_p1 <= '0;
            out_ack_p0 <= 1'b0;
            out_ack_p1 <= 1'b0;
        end else begin
            in_data_p0 <= in.data;
            in_data_p1 <= in_data_p0;
            out_ack_p0 <= out.ack;
            out_ack_p1 <= out_ack_p0;
        end
    end
    assign in_word   = in_data_p1;
    assign out_ack_s = out_ack_p1;
`else
    assign in_word   = in.data;
    assign out_ack_s = out.ack;
`endif

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    in_st_t        in_st;
    out_st_t       out_st;
    logic          in_ack_r;
    logic [W-1:0]  out_data_r;
    cw_t           cls;
    logic          push, pop;

    assign cls   = classify(in_word);
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = (in_st == IN_IDLE) && !full && (cls == CW_COMPLETE);
    assign pop   = (out_st == OUT_DATA) && out_ack_s;

    assign in.ack   = in_ack_r;
    assign out.data = out_data_r;

    // Storage carries no reset; only pointers and occupancy define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_st    <= IN_IDLE;
            in_ack_r <= 1'b0;
            wr_ptr   <= '0;
            err      <= 1'b0;
        end else begin
            case (in_st)
                IN_IDLE: begin
                    if (push) begin
                        wr_ptr   <= next_ptr(wr_ptr);
                        in_ack_r <= 1'b1;
                        in_st    <= IN_ACK;
                    end else if (!full && cls == CW_INVALID) begin
                        // Drop the bad word but still acknowledge so the sender can return to zero
                        err      <= 1'b1;
                        in_ack_r <= 1'b1;
                        in_st    <= IN_ACK;
                    end
                end
                IN_ACK: begin
                    if (cls == CW_SPACER) begin
                        in_ack_r <= 1'b0;
                        in_st    <= IN_IDLE;
                    end
                end
                default: begin
                    in_ack_r <= 1'b0;
                    in_st    <= IN_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_st     <= OUT_IDLE;
            out_data_r <= '0;
            rd_ptr     <= '0;
        end else begin
            case (out_st)
                OUT_IDLE: begin
                    if (!empty && !out_ack_s) begin
                        out_data_r <= mem[rd_ptr];
                        out_st     <= OUT_DATA;
                    end
                end
                OUT_DATA: begin
                    if (out_ack_s) begin
                        out_data_r <= '0;
                        rd_ptr     <= next_ptr(rd_ptr);
                        out_st     <= OUT_RTZ;
                    end
                end
                OUT_RTZ: begin
                    if (!out_ack_s) out_st <= OUT_IDLE;
                end
                default: begin
                    out_data_r <= '0;
                    out_st     <= OUT_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + 1'b1;
        end else if (pop && !push) begin
            count <= count - 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_reg_fifo.sv
// Directed scoreboard bench for mem_reg_fifo: a DEPTH=4 instance for the main flow and a DEPTH=3 one for pointer wrap.
module tb_mem_reg_fifo;
    logic clk;
    logic rst;

    link_intf #(.W(4)) ia ();
    link_intf #(.W(4)) oa ();
    link_intf #(.W(4)) ib ();
    link_intf #(.W(4)) ob ();

    logic [2:0] cnt_a;
    logic       full_a, empty_a, err_a;
    logic [1:0] cnt_b;
    logic       full_b, empty_b, err_b;

    mem_reg_fifo #(.REG_WIDTH(2), .RAIL_NUM(2), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .in(ia), .out(oa),
        .count(cnt_a), .full(full_a), .empty(empty_a), .err(err_a)
    );

    mem_reg_fifo #(.REG_WIDTH(2), .RAIL_NUM(2), .DEPTH(3)) dut_b (
        .clk(clk), .rst(rst), .in(ib), .out(ob),
        .count(cnt_b), .full(full_b), .empty(empty_b), .err(err_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] qa[$];
    logic [3:0] qb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required summary");
        $fatal(1, "watchdog");
    end

    // Dual-rail encoding of a 2-digit value: digit bit b -> rails {b, ~b}
    function automatic logic [3:0] enc(input int v);
        logic [1:0] b;
        b = v[1:0];
        return {b[1], ~b[1], b[0], ~b[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input string tag, input logic [3:0] w);
        ia.data = w;
        tick();
        chk({tag, "_ack1"}, ia.ack, 1);
        qa.push_back(w);
        ia.data = 4'b0000;
        tick();
        chk({tag, "_ack0"}, ia.ack, 0);
    endtask

    task automatic recv_a(input string tag);
        int n;
        logic [3:0] e;
        n = 0;
        while (oa.data == 4'b0000 && n < 10) begin
            tick();
            n++;
        end
        e = (qa.size() > 0) ? qa.pop_front() : 4'b0000;
        chk({tag, "_data"}, oa.data, e);
        oa.ack = 1'b1;
        tick();
        chk({tag, "_rtz"}, oa.data, 0);
        oa.ack = 1'b0;
        tick();
    endtask

    initial begin
        logic [3:0] w;
        rst     = 1'b0;
        ia.data = 4'b0000;
        oa.ack  = 1'b0;
        ib.data = 4'b0000;
        ob.ack  = 1'b0;
        tick();
        tick();
        chk("rst_ack", ia.ack, 0);
        chk("rst_out", oa.data, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_empty", empty_a, 1);
        chk("rst_full", full_a, 0);
        chk("rst_err", err_a, 0);
        rst = 1'b1;
        tick();

        // Single word latency
        ia.data = 4'b1001;
        qa.push_back(4'b1001);
        tick();
        chk("lat_ack", ia.ack, 1);
        chk("lat_count", cnt_a, 1);
        chk("lat_empty", empty_a, 0);
        tick();
        chk("lat_out", oa.data, qa.pop_front());
        ia.data = 4'b0000;
        tick();
        chk("lat_ack0", ia.ack, 0);
        oa.ack = 1'b1;
        tick();
        chk("lat_rtz", oa.data, 0);
        chk("lat_cnt0", cnt_a, 0);
        oa.ack = 1'b0;
        tick();

        // Fill to full, then a held fifth word must not be acknowledged
        for (int i = 0; i < 4; i++) push_a("fill", enc(i));
        chk("fill_count", cnt_a, 4);
        chk("fill_full", full_a, 1);
        ia.data = enc(0);
        tick();
        tick();
        tick();
        chk("full_noack", ia.ack, 0);
        chk("full_count", cnt_a, 4);
        ia.data = 4'b0000;
        tick();
        for (int i = 0; i < 4; i++) recv_a("drain");
        chk("drain_empty", empty_a, 1);
        chk("drain_count", cnt_a, 0);

        // Invalid codeword: acked, dropped, sticky error
        ia.data = 4'b0011;
        tick();
        chk("inv_err", err_a, 1);
        chk("inv_ack", ia.ack, 1);
        chk("inv_count", cnt_a, 0);
        ia.data = 4'b0000;
        tick();
        chk("inv_ack0", ia.ack, 0);
        push_a("post_inv", enc(2));
        chk("err_sticky", err_a, 1);
        recv_a("post_inv");

        // Partial word held, then completed
        ia.data = 4'b0001;
        for (int i = 0; i < 5; i++) tick();
        chk("part_noack", ia.ack, 0);
        chk("part_count", cnt_a, 0);
        ia.data = 4'b1001;
        qa.push_back(4'b1001);
        tick();
        chk("part_ack", ia.ack, 1);
        ia.data = 4'b0000;
        tick();
        recv_a("part");

        // DEPTH=3 stream with push and pop on the same edge, across pointer wrap
        ib.data = enc(1);
        qb.push_back(enc(1));
        tick();
        ib.data = 4'b0000;
        tick();
        ib.data = enc(2);
        qb.push_back(enc(2));
        tick();
        ib.data = 4'b0000;
        tick();
        chk("strm_pre_cnt", cnt_b, 2);
        chk("strm_first", ob.data, qb.pop_front());
        for (int i = 0; i < 7; i++) begin
            w = enc(i + 3);
            ib.data = w;
            qb.push_back(w);
            ob.ack = 1'b1;
            tick();
            chk("strm_cnt", cnt_b, 2);
            chk("strm_ack", ib.ack, 1);
            chk("strm_rtz", ob.data, 0);
            ib.data = 4'b0000;
            ob.ack  = 1'b0;
            tick();
            tick();
            chk("strm_data", ob.data, qb.pop_front());
        end
        ob.ack = 1'b1;
        tick();
        ob.ack = 1'b0;
        tick();
        tick();
        chk("strm_last", ob.data, qb.pop_front());
        chk("strm_last_cnt", cnt_b, 1);

        // Asynchronous reset mid-handshake
        ia.data = enc(1);
        tick();
        chk("mid_ack", ia.ack, 1);
        tick();
        chk("mid_out", oa.data, enc(1));
        #2;
        rst = 1'b0;
        #1;
        chk("arst_ack", ia.ack, 0);
        chk("arst_out", oa.data, 0);
        chk("arst_count", cnt_a, 0);
        chk("arst_empty", empty_a, 1);
        chk("arst_err", err_a, 0);
        chk("arst_b_out", ob.data, 0);
        ia.data = 4'b0000;
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_out", oa.data, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_reg_fifo.md
Name: mem_reg_fifo

Overview:
- Clocked, parametrised successor to the single-word delay-insensitive memory register.
- Accepts 1-of-RAIL_NUM encoded words of REG_WIDTH digits on a four-phase return-to-zero link.
- Buffers up to DEPTH words and replays them in order on an outgoing four-phase link.
- Sits between asynchronous link pipelines and clocked logic, and adds occupancy and codeword-error status.

Parameters:
- REG_WIDTH, 2: digits per word.
- RAIL_NUM, 2: rails per digit (1-of-N encoding; 2 = dual-rail).
- DEPTH, 4: buffered words, >=2; need not be a power of two.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-low.
- in  link_intf.in  data REG_WIDTH*RAIL_NUM in, ack 1 out  incoming four-phase link.
- out  link_intf.out  data REG_WIDTH*RAIL_NUM out, ack 1 in  outgoing four-phase link.
- count  output  $clog2(DEPTH+1)  words stored.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- err  output  1  sticky; set on an invalid incoming codeword.

Behaviour:
- Codeword classes (per digit d = rails [d*RAIL_NUM +: RAIL_NUM]):
  - spacer: all rails 0.
  - complete: every digit exactly one-hot.
  - invalid: any digit with >1 rail hot.
  - partial: otherwise.
- Reset (rst=0, async): in.ack=0, out.data=0 (spacer), count=0, empty=1, full=0, err=0, both FSMs to IDLE, pointers=0. Storage contents are don't-care.
- Input FSM:
  - IN_IDLE: in.ack=0. Complete word and !full -> write word at wr_ptr, wr_ptr++ (wraps DEPTH-1->0), go IN_ACK.
  - IN_IDLE, invalid word: err<=1, no write, go IN_ACK (drop and ack so the sender cannot deadlock).
  - IN_IDLE, partial word or spacer: stay.
  - IN_IDLE, full: stay with ack=0 whatever the word is.
  - IN_ACK: in.ack=1 (registered). Spacer -> IN_IDLE; otherwise stay.
- Output FSM:
  - OUT_IDLE: out.data=spacer. Requires !empty and out.ack==0 -> go OUT_DATA.
  - OUT_DATA: out.data=mem[rd_ptr] (registered copy). out.ack==1 -> pop (rd_ptr++ with wrap, count--), go OUT_RTZ.
  - OUT_RTZ: out.data=spacer. out.ack==0 -> OUT_IDLE.
- Latency:
  - Complete word sampled at edge k: in.ack=1 and count+1 after edge k.
  - out.data shows the word after edge k+1 when the buffer was empty and out.ack=0.
  - Minimum two cycles per phase on each side.
- Simultaneous push and pop in one cycle: count unchanged; both pointers advance.
- Pop and push never target the same entry when full, because no push is allowed while full.
- out.data is driven only from flops, so there are no glitches between codeword and spacer.
- out.ack rising outside OUT_DATA is ignored.
- Reset mid-handshake: both links return to the spacer/ack=0 state immediately; stored words are lost.
- count, full and empty update on the same edge as the push or pop.

Optional Feature:
- MEM_REG_FIFO_SYNC_EN defined: in.data and out.ack each pass through a 2-flop synchroniser (reset 0) before FSM use. Input latency +2 cycles; output ack detection +2 cycles. For links from unclocked logic.
- Not defined: in.data and out.ack are sampled directly. The source must be synchronous to clk.

Test Plan:
- Reset, then REG_WIDTH=2, RAIL_NUM=2: drive in.data=4'b1001 (digit1=1, digit0=0) -> in.ack=1 one edge later, count=1; out.data=4'b1001 one edge after that. Spacer in -> in.ack=0.
- Push 4 words 0,1,2,3 with out.ack held 0 -> full=1, count=4. Fifth complete word -> in.ack stays 0. Then pulse out.ack four times -> words appear as 0,1,2,3, then empty=1.
- in.data=4'b0011 (digit0 both rails hot) -> err=1, in.ack=1, count unchanged. err stays 1 through later valid words until rst.
- Partial word 4'b0001 held 5 cycles -> no ack. Complete it to 4'b1001 -> ack next edge.
- Steady stream with concurrent push/pop at count=2 -> count stays 2, order preserved across pointer wrap (DEPTH=3 build).
- Assert rst low while out in OUT_DATA and in in IN_ACK -> out.data=0, in.ack=0, count=0 asynchronously, before the next clk edge.
